// File: rtl/ser160_parser.sv
// ser160_parser: parallel-to-serial framer for the 160 Mbit/s deserializer path.
// Accepts 16-bit frame words from a source FIFO and emits them as a nibble
// stream, one nibble per sync slot, with start (tin) and stop (tout) strobes.
// Word format: [15] start mark, [14] end mark, [13:12] reserved,
// [11:0] three nibbles, sent MSB nibble first.
//
// Optional feature: define SER160_UNDERRUN_CNT_EN to build the saturating
// underrun-slot counter; otherwise underrun_cnt is tied to zero.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   sync         slot enable; slot state advances on clk edges with sync=1
//   ctrl         {enable, delay[2:0]}; delay = extra output latency in slots
//   valid, data  source word handshake (word sampled on the accepting edge)
//   rd           one-clk acknowledge that data was consumed
//   dout         serial nibble output (delayed by ctrl delay)
//   tin          frame-start strobe (not delayed)
//   tout         frame-stop strobe (delayed with dout)
//   underrun     sticky: source ran dry mid-frame
//   err          sticky: word without start mark offered while idle
//   underrun_cnt saturating count of underrun slots

module ser160_parser #(
    parameter logic [3:0]  IDLE_NIBBLE = 4'h0,
    parameter int unsigned MIN_GAP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic [3:0]  ctrl,
    input  logic        valid,
    input  logic [15:0] data,
    output logic        rd,
    output logic [3:0]  dout,
    output logic        tin,
    output logic        tout,
    output logic        underrun,
    output logic        err,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned GAP_W    = 4;
    localparam int unsigned STAGES   = 8;
    localparam int unsigned LINE_W   = 5;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_N0,
        S_N1,
        S_N2,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                         state;
    logic                           word_end;
    logic [7:0]                     word_lo;
    logic [GAP_W-1:0]               gap_cnt;
    logic [STAGES-1:0][LINE_W-1:0]  dline;

    logic       enable;
    logic [2:0] delay;

    assign enable = ctrl[3];
    assign delay  = ctrl[2:0];

    // Reserved bits are carried by the source but have no meaning here.
    logic unused_rsvd;
    assign unused_rsvd = &{1'b0, data[13:12]};

    // Output tap follows ctrl delay immediately; stage 0 holds the current slot.
    assign dout = dline[delay][3:0];
    assign tout = dline[delay][4];

    // Slot FSM, word latch and delay line. Stage 0 of the line is loaded with
    // the nibble of the slot that starts at this edge, so delay=0 shows it at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            word_end <= 1'b0;
            word_lo  <= '0;
            gap_cnt  <= '0;
            dline    <= '0;
            rd       <= 1'b0;
            tin      <= 1'b0;
            underrun <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd <= 1'b0;
            if (sync) begin
                tin                <= 1'b0;
                dline[STAGES-1:1]  <= dline[STAGES-2:0];
                dline[0]           <= {1'b0, IDLE_NIBBLE};
                if (!enable) begin
                    state    <= S_IDLE;
                    underrun <= 1'b0;
                    err      <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (valid) begin
                                rd <= 1'b1;
                                if (data[15]) begin
                                    word_end <= data[14];
                                    word_lo  <= data[7:0];
                                    dline[0] <= {1'b0, data[11:8]};
                                    tin      <= 1'b1;
                                    state    <= S_N0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        end
                        S_N0: begin
                            dline[0] <= {1'b0, word_lo[7:4]};
                            state    <= S_N1;
                        end
                        S_N1: begin
                            dline[0] <= {word_end, word_lo[3:0]};
                            state    <= S_N2;
                        end
                        S_N2: begin
                            if (word_end) begin
                                gap_cnt <= GAP_INIT;
                                state   <= S_GAP;
                            end else if (valid) begin
                                // Start mark of a continuation word is ignored.
                                rd       <= 1'b1;
                                word_end <= data[14];
                                word_lo  <= data[7:0];
                                dline[0] <= {1'b0, data[11:8]};
                                state    <= S_N0;
                            end else begin
                                underrun <= 1'b1;
                                state    <= S_WAIT;
                            end
                        end
                        S_WAIT: begin
                            if (valid) begin
                                rd       <= 1'b1;
                                word_end <= data[14];
                                word_lo  <= data[7:0];
                                dline[0] <= {1'b0, data[11:8]};
                                state    <= S_N0;
                            end
                        end
                        S_GAP: begin
                            if (gap_cnt <= GAP_W'(1)) begin
                                state <= S_IDLE;
                            end else begin
                                gap_cnt <= gap_cnt - GAP_W'(1);
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef SER160_UNDERRUN_CNT_EN
    // True when the slot starting at this edge is a WAIT slot.
    logic wait_next_c;
    assign wait_next_c = enable && !valid &&
                         ((state == S_N2 && !word_end) || state == S_WAIT);

    // Saturating count of WAIT slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 8'h00;
        end else if (sync) begin
            if (!enable) begin
                underrun_cnt <= 8'h00;
            end else if (wait_next_c && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ser160_parser.sv
// Testbench for ser160_parser: randomized and directed frame streams compared
// slot by slot against a frame-schedule model, plus directed error, enable
// and reset scenarios.

module tb_ser160_parser;

    localparam int G  = 2;
    localparam int NS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync;
    logic [3:0]  ctrl;
    logic        valid;
    logic [15:0] data;
    logic        rd;
    logic [3:0]  dout;
    logic        tin;
    logic        tout;
    logic        underrun;
    logic        err;
    logic [7:0]  underrun_cnt;

    ser160_parser dut (
        .clk          (clk),
        .reset        (reset),
        .sync         (sync),
        .ctrl         (ctrl),
        .valid        (valid),
        .data         (data),
        .rd           (rd),
        .dout         (dout),
        .tin          (tin),
        .tout         (tout),
        .underrun     (underrun),
        .err          (err),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame schedule model: expected pre-delay stream per slot.
    logic [3:0]  pre_nib [NS];
    bit          pre_tout [NS];
    bit          pre_tin [NS];
    bit          exp_rd [NS];
    logic [15:0] w_q [$];
    int          r_q [$];
    int          avail_q [$];
    bit          exp_under;
    int          exp_ucnt;
    int          last_slot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One slot: at least one low clk, then a one-clk sync pulse; returns at
    // the negedge right after the sync edge.
    task automatic step();
        @(negedge clk);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sync  = 1'b0;
        valid = 1'b0;
        data  = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Word j is accepted at slot a_j. A frame start may come no earlier than
    // 4+G slots after the previous frame's last acceptance; a continuation no
    // earlier than 3 slots after the previous word. Late words mean WAIT slots.
    task automatic build_model();
        int  earliest;
        int  last_a;
        int  a;
        int  av;
        bit  in_frame;
        earliest = 0;
        last_a   = 0;
        in_frame = 1'b0;
        for (int i = 0; i < NS; i++) begin
            pre_nib[i]  = 4'h0;
            pre_tout[i] = 1'b0;
            pre_tin[i]  = 1'b0;
            exp_rd[i]   = 1'b0;
        end
        avail_q.delete();
        exp_under = 1'b0;
        exp_ucnt  = 0;
        for (int j = 0; j < w_q.size(); j++) begin
            if (!in_frame) begin
                av = earliest + r_q[j];
                if (av < 0) av = 0;
                a = (av > earliest) ? av : earliest;
                pre_tin[a] = 1'b1;
                in_frame   = 1'b1;
            end else begin
                av = last_a + 3 + r_q[j];
                a  = (av > last_a + 3) ? av : last_a + 3;
                if (a > last_a + 3) begin
                    exp_under = 1'b1;
                    exp_ucnt += a - last_a - 3;
                end
            end
            pre_nib[a]     = w_q[j][11:8];
            pre_nib[a + 1] = w_q[j][7:4];
            pre_nib[a + 2] = w_q[j][3:0];
            exp_rd[a]      = 1'b1;
            if (w_q[j][14]) begin
                pre_tout[a + 2] = 1'b1;
                in_frame        = 1'b0;
                earliest        = a + 4 + G;
            end
            avail_q.push_back(av);
            last_a = a;
        end
        last_slot = last_a + 4 + G + 4;
    endtask

    task automatic set_src(input int next_slot, input int idx);
        if (idx < w_q.size() && next_slot >= avail_q[idx]) begin
            valid = 1'b1;
            data  = w_q[idx];
        end else begin
            valid = 1'b0;
            data  = 16'($urandom);
        end
    endtask

    task automatic run_section(input string name, input int d);
        int idx;
        int ucnt_exp;
        build_model();
        do_reset();
        ctrl = {1'b1, 3'(d)};
        check({name, " reset dout"}, 32'(dout), 32'h0);
        check({name, " reset tin/tout/rd"}, 32'({tin, tout, rd}), 32'h0);
        check({name, " reset flags"}, 32'({underrun, err, underrun_cnt}), 32'h0);
        idx = 0;
        set_src(0, idx);
        for (int n = 0; n <= last_slot + d; n++) begin
            step();
            check($sformatf("%s dout[%0d]", name, n), 32'(dout),
                  32'((n >= d) ? pre_nib[n - d] : 4'h0));
            check($sformatf("%s tout[%0d]", name, n), 32'(tout),
                  32'((n >= d) ? pre_tout[n - d] : 1'b0));
            check($sformatf("%s tin[%0d]", name, n), 32'(tin), 32'(pre_tin[n]));
            check($sformatf("%s rd[%0d]", name, n), 32'(rd), 32'(exp_rd[n]));
            if (rd && idx < w_q.size()) idx++;
            set_src(n + 1, idx);
        end
        ucnt_exp = 0;
`ifdef SER160_UNDERRUN_CNT_EN
        ucnt_exp = (exp_ucnt > 255) ? 255 : exp_ucnt;
`endif
        check({name, " words consumed"}, 32'(idx), 32'(w_q.size()));
        check({name, " underrun"}, 32'(underrun), 32'(exp_under));
        check({name, " underrun_cnt"}, 32'(underrun_cnt), 32'(ucnt_exp));
        check({name, " err"}, 32'(err), 32'h0);
    endtask

    task automatic gen_random();
        int          nf;
        int          k;
        logic [15:0] w;
        w_q.delete();
        r_q.delete();
        nf = int'($urandom_range(3, 6));
        for (int f = 0; f < nf; f++) begin
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) begin
                w = 16'($urandom);
                if (j == 0) w[15] = 1'b1;
                w[14] = (j == k - 1);
                w_q.push_back(w);
                if (j == 0) r_q.push_back(int'($urandom_range(0, G + 3)) - (G + 1));
                else        r_q.push_back(int'($urandom_range(0, 7)) - 2);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        sync  = 1'b0;
        ctrl  = 4'h0;
        valid = 1'b0;
        data  = 16'h0;

        // Back-to-back two-word frame, no delay.
        w_q = '{16'h8ABC, 16'h4123};
        r_q = '{0, 0};
        run_section("b2b", 0);

        // One-word frame through a delay of 3 slots.
        w_q = '{16'hC5A7};
        r_q = '{2};
        run_section("dly3", 3);

        // Source runs dry for four slots mid-frame.
        w_q = '{16'h8111, 16'h4222};
        r_q = '{0, 4};
        run_section("undr", 0);

        for (int s = 0; s < 5; s++) begin
            gen_random();
            run_section($sformatf("rnd%0d", s), int'($urandom_range(0, 7)));
        end

        // Non-start word offered while idle.
        do_reset();
        ctrl  = 4'h8;
        valid = 1'b1;
        data  = 16'h0FFF;
        step();
        check("bad rd", 32'(rd), 32'h1);
        check("bad err", 32'(err), 32'h1);
        check("bad tin", 32'(tin), 32'h0);
        check("bad dout", 32'(dout), 32'h0);
        valid = 1'b0;
        step();
        check("bad dout idle", 32'(dout), 32'h0);
        check("bad err sticky", 32'(err), 32'h1);

        // Enable dropped during the N1 slot.
        valid = 1'b1;
        data  = 16'h8DEF;
        step();
        check("en tin", 32'(tin), 32'h1);
        check("en nib0", 32'(dout), 32'hD);
        check("en rd", 32'(rd), 32'h1);
        step();
        check("en nib1", 32'(dout), 32'hE);
        ctrl = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("en off dout %0d", i), 32'(dout), 32'h0);
            check($sformatf("en off tout %0d", i), 32'(tout), 32'h0);
            check($sformatf("en off rd/tin %0d", i), 32'({rd, tin}), 32'h0);
            check($sformatf("en off flags %0d", i), 32'({underrun, err, underrun_cnt}), 32'h0);
        end

        // Reset asserted mid-frame, then a normal frame.
        ctrl  = 4'h8;
        valid = 1'b1;
        data  = 16'h8ABC;
        step();
        valid = 1'b0;
        step();
        check("rst pre nib", 32'(dout), 32'hB);
        reset = 1'b1;
        #1;
        check("rst dout", 32'(dout), 32'h0);
        check("rst strobes", 32'({tin, tout, rd}), 32'h0);
        check("rst flags", 32'({underrun, err, underrun_cnt}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b1;
        data  = 16'h8123;
        step();
        check("post tin", 32'(tin), 32'h1);
        check("post nib0", 32'(dout), 32'h1);
        check("post rd", 32'(rd), 32'h1);
        valid = 1'b0;
        step();
        check("post nib1", 32'(dout), 32'h2);
        check("post tin off", 32'(tin), 32'h0);
        step();
        check("post nib2", 32'(dout), 32'h3);
        check("post tout", 32'(tout), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
